// File: rtl/usb_bit_pkg.sv
// Bit-level constants and receive FSM state type shared by the USB transmit stuffer and
// receive deserializer.
package usb_bit_pkg;

   localparam int unsigned USB_BYTE_W      = 8;
   localparam int unsigned USB_STUFF_LIMIT = 6;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ERROR
   } rx_state_t;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Counts consecutive accepted 1s and classifies each strobed bit as data, a stuff bit to drop,
// or a stuff violation (a 1 where a stuff 0 was required).
module usb_bit_unstuffer
   import usb_bit_pkg::*;
#(
   parameter int unsigned STUFF_LIMIT = USB_STUFF_LIMIT
) (
   input  logic clk,
   input  logic nRST,
   input  logic clear,
   input  logic strobe,
   input  logic serial_bit,
   output logic bit_accept,
   output logic stuff_drop,
   output logic stuff_violation
);

   localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);

   logic [OnesW-1:0] ones_cnt_q, ones_cnt_d;
   logic             at_limit;

   assign at_limit        = (ones_cnt_q == OnesW'(STUFF_LIMIT));
   assign bit_accept      = strobe && !at_limit;
   assign stuff_drop      = strobe && at_limit && !serial_bit;
   assign stuff_violation = strobe && at_limit && serial_bit;

   // Accepted bits never occur at the limit, so the increment saturates by construction.
   always_comb begin
      ones_cnt_d = ones_cnt_q;
      if (clear) begin
         ones_cnt_d = '0;
      end else if (strobe && at_limit) begin
         ones_cnt_d = '0;
      end else if (bit_accept) begin
         ones_cnt_d = serial_bit ? ones_cnt_q + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ones_cnt_q <= '0;
      end else begin
         ones_cnt_q <= ones_cnt_d;
      end
   end

endmodule

// File: rtl/sipo_rx_deserializer.sv
// Receive SIPO: MSB-first serial bits into bytes behind a one-entry valid/ready holding register.
// Define USB_BIT_UNSTUFF_EN to enable USB stuff-bit removal and stuff_err reporting.
module sipo_rx_deserializer
   import usb_bit_pkg::*;
#(
   parameter int unsigned DATA_W      = USB_BYTE_W,
   parameter int unsigned STUFF_LIMIT = USB_STUFF_LIMIT
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              rx_active,
   input  logic              sample_enable,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              overrun,
   output logic              stuff_err,
   output logic              frame_err
);

   localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic              rx_active_q;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] new_byte;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic              stuff_err_q, stuff_err_d;
   logic              frame_err_q, frame_err_d;
   logic              strobe, bit_accept, stuff_violation;
   logic              complete, consume, rise, fall;

   assign strobe   = sample_enable && rx_active && (state_q == SHIFT);
   assign new_byte = {shreg_q[DATA_W-2:0], serial_in};
   assign complete = bit_accept && (bit_cnt_q == LastBit);
   assign consume  = valid_q && data_ready;
   assign rise     = rx_active && !rx_active_q;
   assign fall     = rx_active_q && !rx_active;

`ifdef USB_BIT_UNSTUFF_EN
   logic stuff_drop;

   usb_bit_unstuffer #(
      .STUFF_LIMIT(STUFF_LIMIT)
   ) u_unstuffer (
      .clk            (clk),
      .nRST           (nRST),
      .clear          (!rx_active),
      .strobe         (strobe),
      .serial_bit     (serial_in),
      .bit_accept     (bit_accept),
      .stuff_drop     (stuff_drop),
      .stuff_violation(stuff_violation)
   );
`else
   assign bit_accept      = strobe;
   assign stuff_violation = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      hold_d      = hold_q;
      valid_d     = valid_q;
      overrun_d   = 1'b0;
      stuff_err_d = stuff_err_q;
      frame_err_d = 1'b0;

      if (consume) begin
         valid_d = 1'b0;
      end
      // A byte may load in the same cycle the previous one is consumed.
      if (complete) begin
         if (!valid_q || consume) begin
            hold_d  = new_byte;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (!rx_active) begin
         state_d     = IDLE;
         shreg_d     = '0;
         bit_cnt_d   = '0;
         stuff_err_d = 1'b0;
         frame_err_d = fall && (state_q == SHIFT) && (bit_cnt_q != '0);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (stuff_violation) begin
                  state_d     = ERROR;
                  stuff_err_d = 1'b1;
                  shreg_d     = '0;
                  bit_cnt_d   = '0;
               end else if (bit_accept) begin
                  shreg_d   = new_byte;
                  bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
               end
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         rx_active_q <= 1'b0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         stuff_err_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_active_q <= rx_active;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         stuff_err_q <= stuff_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data_out   = hold_q;
   assign data_valid = valid_q;
   assign overrun    = overrun_q;
   assign stuff_err  = stuff_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_rx_deserializer.sv
// Self-checking bench for sipo_rx_deserializer; a negedge monitor pops the byte scoreboard on
// every data_valid && data_ready handshake.
module tb_sipo_rx_deserializer;

   logic       clk = 1'b0;
   logic       nRST;
   logic       rx_active;
   logic       sample_enable;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       overrun;
   logic       stuff_err;
   logic       frame_err;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         tx_ones     = 0;

   always #5 clk = ~clk;

   sipo_rx_deserializer dut (
      .clk          (clk),
      .nRST         (nRST),
      .rx_active    (rx_active),
      .sample_enable(sample_enable),
      .serial_in    (serial_in),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .overrun      (overrun),
      .stuff_err    (stuff_err),
      .frame_err    (frame_err)
   );

   // Scoreboard consumer: every handshake must match the oldest expected byte.
   always @(negedge clk) begin
      if (nRST === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL byte_unexpected: got %02h, required no byte", data_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (data_out !== mon_exp) begin
               miscompares++;
               $display("FAIL byte_data: got %02h, required %02h", data_out, mon_exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic b);
      serial_in     = b;
      sample_enable = 1'b1;
      @(posedge clk);
      #1;
      sample_enable = 1'b0;
      serial_in     = 1'b0;
   endtask

   // Transmitter model: a stuff 0 precedes any bit that follows six consecutive 1s.
   task automatic send_bit(input logic b);
`ifdef USB_BIT_UNSTUFF_EN
      if (tx_ones == 6) begin
         strobe(1'b0);
         tx_ones = 0;
      end
`endif
      strobe(b);
      tx_ones = b ? tx_ones + 1 : 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic start_frame();
      rx_active = 1'b1;
      tx_ones   = 0;
      tick(2);
   endtask

   task automatic end_frame();
      rx_active = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      nRST = 1'b0; rx_active = 1'b0; sample_enable = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
      tick(3);
      vectors++; if (data_out !== 8'h00) begin miscompares++;
         $display("FAIL reset_data_out: got %02h, required 00", data_out); end
      vectors++; if (data_valid !== 1'b0) begin miscompares++;
         $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
      vectors++; if (overrun !== 1'b0) begin miscompares++;
         $display("FAIL reset_overrun: got %b, required 0", overrun); end
      vectors++; if (stuff_err !== 1'b0) begin miscompares++;
         $display("FAIL reset_stuff_err: got %b, required 0", stuff_err); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++;
         $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
      nRST = 1'b1;
      tick(2);
   endtask

   task automatic test_basic();
      data_ready = 1'b1;
      start_frame();
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      vectors++; if (data_valid !== 1'b1) begin miscompares++;
         $display("FAIL basic_latency: data_valid got %b, required 1", data_valid); end
      vectors++; if (data_out !== 8'hA5) begin miscompares++;
         $display("FAIL basic_data: got %02h, required a5", data_out); end
      vectors++; if ({overrun, stuff_err, frame_err} !== 3'b000) begin miscompares++;
         $display("FAIL basic_flags: got %b, required 000", {overrun, stuff_err, frame_err}); end
      tick(1);
      vectors++; if (data_valid !== 1'b0) begin miscompares++;
         $display("FAIL basic_consumed: data_valid got %b, required 0", data_valid); end
      rx_active = 1'b0;
      tick(1);
      vectors++; if (frame_err !== 1'b0) begin miscompares++;
         $display("FAIL basic_clean_end: frame_err got %b, required 0", frame_err); end
      tick(1);
   endtask

   task automatic test_overrun();
      data_ready = 1'b0;
      start_frame();
      exp_q.push_back(8'hFF);
      send_byte(8'hFF);
      vectors++; if (data_valid !== 1'b1 || data_out !== 8'hFF) begin miscompares++;
         $display("FAIL ovr_first: got valid=%b data=%02h, required valid=1 data=ff",
                  data_valid, data_out); end
      send_byte(8'h00);
      vectors++; if (overrun !== 1'b1) begin miscompares++;
         $display("FAIL ovr_pulse: got %b, required 1", overrun); end
      vectors++; if (data_out !== 8'hFF) begin miscompares++;
         $display("FAIL ovr_held: got %02h, required ff", data_out); end
      tick(1);
      vectors++; if (overrun !== 1'b0) begin miscompares++;
         $display("FAIL ovr_one_cycle: got %b, required 0", overrun); end
      vectors++; if (data_valid !== 1'b1) begin miscompares++;
         $display("FAIL ovr_still_valid: got %b, required 1", data_valid); end
      data_ready = 1'b1;
      tick(1);
      vectors++; if (data_valid !== 1'b0) begin miscompares++;
         $display("FAIL ovr_release: data_valid got %b, required 0", data_valid); end
      end_frame();
   endtask

`ifdef USB_BIT_UNSTUFF_EN
   task automatic test_stuff();
      logic [8:0] seq;
      data_ready = 1'b1;
      start_frame();
      exp_q.push_back(8'hFF);
      seq = 9'b1_1111_1011;
      for (int i = 8; i >= 0; i--) strobe(seq[i]);
      vectors++; if (data_valid !== 1'b1 || data_out !== 8'hFF) begin miscompares++;
         $display("FAIL stuff_drop: got valid=%b data=%02h, required valid=1 data=ff",
                  data_valid, data_out); end
      vectors++; if (stuff_err !== 1'b0) begin miscompares++;
         $display("FAIL stuff_no_err: got %b, required 0", stuff_err); end
      tick(1);
      end_frame();
      start_frame();
      for (int i = 0; i < 7; i++) strobe(1'b1);
      vectors++; if (stuff_err !== 1'b1) begin miscompares++;
         $display("FAIL stuff_violation: got %b, required 1", stuff_err); end
      strobe(1'b1);
      strobe(1'b0);
      tick(1);
      vectors++; if (data_valid !== 1'b0 || stuff_err !== 1'b1) begin miscompares++;
         $display("FAIL stuff_error_hold: got valid=%b err=%b, required valid=0 err=1",
                  data_valid, stuff_err); end
      rx_active = 1'b0;
      tick(1);
      vectors++; if (stuff_err !== 1'b0 || frame_err !== 1'b0) begin miscompares++;
         $display("FAIL stuff_clear: got err=%b frame=%b, required 0 0", stuff_err, frame_err); end
      tick(1);
   endtask
`else
   task automatic test_stuff();
      logic [7:0] seq;
      data_ready = 1'b1;
      start_frame();
      exp_q.push_back(8'hFD);
      seq = 8'hFD;
      for (int i = 7; i >= 0; i--) strobe(seq[i]);
      vectors++; if (data_valid !== 1'b1 || data_out !== 8'hFD) begin miscompares++;
         $display("FAIL nostuff_data: got valid=%b data=%02h, required valid=1 data=fd",
                  data_valid, data_out); end
      vectors++; if (stuff_err !== 1'b0) begin miscompares++;
         $display("FAIL nostuff_err: got %b, required 0", stuff_err); end
      tick(1);
      end_frame();
   endtask
`endif

   task automatic test_frame_err();
      logic [4:0] part;
      data_ready = 1'b1;
      start_frame();
      part = 5'b10110;
      for (int i = 4; i >= 0; i--) send_bit(part[i]);
      rx_active = 1'b0;
      tick(1);
      vectors++; if (frame_err !== 1'b1) begin miscompares++;
         $display("FAIL frame_err_pulse: got %b, required 1", frame_err); end
      vectors++; if (data_valid !== 1'b0) begin miscompares++;
         $display("FAIL frame_no_byte: data_valid got %b, required 0", data_valid); end
      tick(1);
      vectors++; if (frame_err !== 1'b0) begin miscompares++;
         $display("FAIL frame_err_one_cycle: got %b, required 0", frame_err); end
      start_frame();
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      vectors++; if (data_valid !== 1'b1 || data_out !== 8'h3C) begin miscompares++;
         $display("FAIL frame_next: got valid=%b data=%02h, required valid=1 data=3c",
                  data_valid, data_out); end
      tick(1);
      end_frame();
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      data_ready = 1'b0;
      start_frame();
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hC3);
      send_byte(8'h5A);
      b = 8'hC3;
      for (int i = 7; i >= 1; i--) send_bit(b[i]);
      data_ready = 1'b1;
      send_bit(b[0]);
      vectors++; if (data_valid !== 1'b1) begin miscompares++;
         $display("FAIL b2b_valid: got %b, required 1", data_valid); end
      vectors++; if (data_out !== 8'hC3) begin miscompares++;
         $display("FAIL b2b_data: got %02h, required c3", data_out); end
      vectors++; if (overrun !== 1'b0) begin miscompares++;
         $display("FAIL b2b_overrun: got %b, required 0", overrun); end
      tick(1);
      vectors++; if (data_valid !== 1'b0) begin miscompares++;
         $display("FAIL b2b_drain: data_valid got %b, required 0", data_valid); end
      end_frame();
   endtask

   task automatic test_reset_midbyte();
      data_ready = 1'b0;
      start_frame();
      send_byte(8'h55);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      vectors++; if (data_valid !== 1'b1) begin miscompares++;
         $display("FAIL rst_pre_valid: got %b, required 1", data_valid); end
      nRST      = 1'b0;
      rx_active = 1'b0;
      #1;
      vectors++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin miscompares++;
         $display("FAIL rst_async_data: got valid=%b data=%02h, required 0 00",
                  data_valid, data_out); end
      vectors++; if ({overrun, stuff_err, frame_err} !== 3'b000) begin miscompares++;
         $display("FAIL rst_async_flags: got %b, required 000", {overrun, stuff_err, frame_err}); end
      tick(2);
      nRST = 1'b1;
      tick(1);
      data_ready = 1'b1;
      start_frame();
      exp_q.push_back(8'h81);
      send_byte(8'h81);
      vectors++; if (data_valid !== 1'b1 || data_out !== 8'h81) begin miscompares++;
         $display("FAIL rst_next: got valid=%b data=%02h, required valid=1 data=81",
                  data_valid, data_out); end
      tick(1);
      end_frame();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_stuff();
      test_frame_err();
      test_back_to_back();
      test_reset_midbyte();
      tick(2);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
